mem_a_feeder: RTL and testbench

- Operand-A buffer directly upstream of the systolic array.
- Holds one DIM x DIM signed matrix A, loaded one row per cycle.
- On start, streams A in diagonal-skewed order over 2*DIM-1 valid cycles: column j of the array sees row elements delayed by j cycles.
- Output ordering matches the skewed-A golden model the array bench already checks against.

---
 rtl/mem_a_feeder_pkg.sv | 19 +
 rtl/mem_a_feeder_if.sv | 40 ++++
 rtl/mem_a_feeder_skew_lane.sv | 29 ++
 rtl/mem_a_feeder.sv | 115 +++++++++++
 tb/tb_mem_a_feeder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_a_feeder_pkg.sv
// Shared types and constants for the operand-A feeder ahead of the systolic array.
// Optional stall input is enabled by defining MEM_A_FEEDER_STALL_EN.
package mem_a_feeder_pkg;

   localparam int unsigned BITS_AB_DEFAULT = 8;
   localparam int unsigned DIM_DEFAULT     = 8;

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      DONE
   } state_t;

   // Number of valid skewed columns emitted per pass.
   function automatic int unsigned skew_len(input int unsigned dim);
      return 2 * dim - 1;
   endfunction

endpackage

// File: rtl/mem_a_feeder_if.sv
// Load/stream bus between the A-matrix source, the feeder and the array.
// Carries a stall line only when MEM_A_FEEDER_STALL_EN is defined.
interface mem_a_feeder_if #(
   parameter int unsigned BITS_AB = 8,
   parameter int unsigned DIM     = 8
);

   logic                        wr_en;
   logic [$clog2(DIM)-1:0]      wr_row;
   logic [DIM*BITS_AB-1:0]      a_in;
   logic                        start;
   logic                        busy;
   logic                        a_valid;
   logic [DIM*BITS_AB-1:0]      a_out;
   logic                        done;
`ifdef MEM_A_FEEDER_STALL_EN
   logic                        stall;

   modport master (
      output wr_en, wr_row, a_in, start, stall,
      input  busy, a_valid, a_out, done
   );

   modport slave (
      input  wr_en, wr_row, a_in, start, stall,
      output busy, a_valid, a_out, done
   );
`else
   modport master (
      output wr_en, wr_row, a_in, start,
      input  busy, a_valid, a_out, done
   );

   modport slave (
      input  wr_en, wr_row, a_in, start,
      output busy, a_valid, a_out, done
   );
`endif

endinterface

// File: rtl/mem_a_feeder_skew_lane.sv
// Combinational lane selector: lane LANE at step k picks A[k-LANE][LANE], or 0 outside the band.
// Not affected by MEM_A_FEEDER_STALL_EN.
module skew_lane_sel
   import mem_a_feeder_pkg::*;
#(
   parameter int unsigned BITS_AB = BITS_AB_DEFAULT,
   parameter int unsigned DIM     = DIM_DEFAULT,
   parameter int unsigned LANE    = 0,
   parameter int unsigned CW      = $clog2(2 * DIM)
) (
   input  logic [CW-1:0]             k_i,
   input  logic signed [BITS_AB-1:0] col_i [DIM],
   output logic signed [BITS_AB-1:0] elem_o
);

   int unsigned k_ext;

   always_comb begin
      k_ext  = 32'(k_i);
      elem_o = '0;
      // Row r reaches this lane exactly when k == r + LANE.
      for (int unsigned r = 0; r < DIM; r++) begin
         if (k_ext == r + LANE) begin
            elem_o = col_i[r];
         end
      end
   end

endmodule

// File: rtl/mem_a_feeder.sv
// Operand-A buffer: stores a DIM x DIM signed matrix by rows and streams it diagonal-skewed.
// Define MEM_A_FEEDER_STALL_EN to add a stall input that freezes the stream in FEED.
module mem_a_feeder
   import mem_a_feeder_pkg::*;
#(
   parameter int unsigned BITS_AB = BITS_AB_DEFAULT,
   parameter int unsigned DIM     = DIM_DEFAULT
) (
   input logic           clk,
   input logic           rst,
   mem_a_feeder_if.slave bus
);

   localparam int unsigned CW   = $clog2(2 * DIM);
   localparam int unsigned LAST = skew_len(DIM) - 1;

   if (DIM < 2) begin : g_dim_check
      $error("mem_a_feeder: DIM must be at least 2");
   end

   state_t                      state_q;
   logic [CW-1:0]               cnt_q;
   logic                        busy_q;
   logic                        a_valid_q;
   logic                        done_q;
   logic [DIM*BITS_AB-1:0]      a_out_q;
   logic [DIM*BITS_AB-1:0]      a_out_d;
   logic signed [BITS_AB-1:0]   mem_q [DIM][DIM];
   logic signed [BITS_AB-1:0]   lane_elem [DIM];
   logic                        wr_ok;
   logic                        hold;

`ifdef MEM_A_FEEDER_STALL_EN
   assign hold = bus.stall;
`else
   assign hold = 1'b0;
`endif

   assign wr_ok = (state_q == IDLE) && bus.wr_en && (32'(bus.wr_row) < DIM);

   // Storage is column-major so each lane selector sees only its own column.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < DIM; c++) begin
            for (int unsigned r = 0; r < DIM; r++) begin
               mem_q[c][r] <= '0;
            end
         end
      end else if (wr_ok) begin
         for (int unsigned c = 0; c < DIM; c++) begin
            mem_q[c][bus.wr_row] <= bus.a_in[c*BITS_AB +: BITS_AB];
         end
      end
   end

   for (genvar j = 0; j < DIM; j++) begin : g_lane
      skew_lane_sel #(
         .BITS_AB (BITS_AB),
         .DIM     (DIM),
         .LANE    (j),
         .CW      (CW)
      ) u_lane (
         .k_i    (cnt_q),
         .col_i  (mem_q[j]),
         .elem_o (lane_elem[j])
      );
      assign a_out_d[j*BITS_AB +: BITS_AB] = lane_elem[j];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         a_valid_q <= 1'b0;
         done_q    <= 1'b0;
         a_out_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               busy_q <= bus.start;
               if (bus.start) begin
                  cnt_q   <= '0;
                  state_q <= FEED;
               end
            end
            FEED: begin
               if (!hold) begin
                  a_out_q   <= a_out_d;
                  a_valid_q <= 1'b1;
                  cnt_q     <= cnt_q + 1'b1;
                  if (cnt_q == CW'(LAST)) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               // Last column is on the bus now; retire it and pulse done.
               a_valid_q <= 1'b0;
               a_out_q   <= '0;
               done_q    <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.a_valid = a_valid_q;
   assign bus.a_out   = a_out_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_mem_a_feeder.sv
// Directed bench for mem_a_feeder (DIM=8, BITS_AB=8); exercises the stall path when
// MEM_A_FEEDER_STALL_EN is defined.
module tb_mem_a_feeder;

   localparam int D = 8;
   localparam int B = 8;

   typedef struct {
      int k;
      int lane;
      int exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_a_feeder_if #(.BITS_AB(B), .DIM(D)) bus_if ();

   mem_a_feeder #(.BITS_AB(B), .DIM(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int model [D][D];
   logic [D*B-1:0] cols [$];
   vec_t tbl [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk64(input string name, input logic [D*B-1:0] act, input logic [D*B-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int lane_of(input logic [D*B-1:0] c, input int j);
      logic signed [B-1:0] b;
      b = c[j*B +: B];
      return int'(b);
   endfunction

   function automatic int exp_lane(input int k, input int j);
      if (k - j >= 0 && k - j <= D - 1) return model[k-j][j];
      return 0;
   endfunction

   function automatic logic [D*B-1:0] exp_col(input int k);
      logic [D*B-1:0] e;
      e = '0;
      for (int j = 0; j < D; j++) e[j*B +: B] = 8'(exp_lane(k, j));
      return e;
   endfunction

   // ramp=1: element c of row r is r*D+c; otherwise every element is v.
   function automatic logic [D*B-1:0] row_data(input int r, input bit ramp, input int v);
      logic [D*B-1:0] d;
      for (int c = 0; c < D; c++) d[c*B +: B] = 8'(ramp ? r * D + c : v);
      return d;
   endfunction

   task automatic model_row(input int r, input bit ramp, input int v);
      for (int c = 0; c < D; c++) model[r][c] = ramp ? r * D + c : v;
   endtask

   task automatic write_row(input int r, input bit ramp, input int v);
      bus_if.wr_en  = 1'b1;
      bus_if.wr_row = 3'(r);
      bus_if.a_in   = row_data(r, ramp, v);
      model_row(r, ramp, v);
      tick();
      bus_if.wr_en = 1'b0;
   endtask

   task automatic run_pass(input string tag, input int mid_wr_at, input int stall_at, input int stall_len);
      int done_cnt = 0;
      bit prev_valid = 0;
      bit prev_done = 0;
      bit finished = 0;
`ifdef MEM_A_FEEDER_STALL_EN
      int stall_rem = 0;
      bit stall_started = 0;
`endif
      cols.delete();
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      bus_if.wr_en = 1'b0;
      chk({tag, "_accept_busy"}, int'(bus_if.busy), 1);
      chk({tag, "_accept_valid"}, int'(bus_if.a_valid), 0);
      for (int t = 0; t < 80 && !finished; t++) begin
         tick();
`ifdef MEM_A_FEEDER_STALL_EN
         if (stall_rem > 0) begin
            stall_rem--;
            if (stall_rem == 0) bus_if.stall = 1'b0;
         end
`endif
         bus_if.wr_en = 1'b0;
         if (bus_if.a_valid) cols.push_back(bus_if.a_out);
         if (bus_if.done) begin
            done_cnt++;
            chk({tag, "_done_after_valid"}, int'(prev_valid), 1);
            chk({tag, "_done_busy"}, int'(bus_if.busy), 1);
            chk({tag, "_done_valid"}, int'(bus_if.a_valid), 0);
            chk64({tag, "_done_aout"}, bus_if.a_out, '0);
         end else if (!bus_if.busy) begin
            finished = 1;
            chk({tag, "_busy_falls_after_done"}, int'(prev_done), 1);
         end
         if (bus_if.a_valid && cols.size() == mid_wr_at) begin
            bus_if.wr_en  = 1'b1;
            bus_if.wr_row = 3'd3;
            bus_if.a_in   = row_data(3, 1'b0, 5);
         end
`ifdef MEM_A_FEEDER_STALL_EN
         if (bus_if.a_valid && !stall_started && stall_len > 0 && cols.size() == stall_at + 1) begin
            stall_started = 1;
            stall_rem     = stall_len;
            bus_if.stall  = 1'b1;
         end
`endif
         prev_valid = bus_if.a_valid;
         prev_done  = bus_if.done;
      end
      chk({tag, "_finished"}, int'(finished), 1);
      chk({tag, "_done_pulses"}, done_cnt, 1);
   endtask

   task automatic check_pass(input string tag, input int stall_at, input int stall_len);
      int klist [$];
      for (int k = 0; k < 2 * D - 1; k++) begin
         klist.push_back(k);
         if (k == stall_at) for (int s = 0; s < stall_len; s++) klist.push_back(k);
      end
      chk({tag, "_valid_cycles"}, cols.size(), klist.size());
      for (int i = 0; i < klist.size() && i < cols.size(); i++)
         chk64($sformatf("%s_col%0d", tag, i), cols[i], exp_col(klist[i]));
   endtask

   task automatic chk_lane(input string name, input int idx, input int j, input int exp);
      if (idx < cols.size()) chk(name, lane_of(cols[idx], j), exp);
      else chk({name, "_missing"}, cols.size(), idx + 1);
   endtask

   initial begin
      bus_if.wr_en  = 1'b0;
      bus_if.wr_row = '0;
      bus_if.a_in   = '0;
      bus_if.start  = 1'b0;
`ifdef MEM_A_FEEDER_STALL_EN
      bus_if.stall  = 1'b0;
`endif
      for (int r = 0; r < D; r++) model_row(r, 1'b0, 0);

      tbl[0] = '{0, 0, 0};
      tbl[1] = '{1, 0, 8};
      tbl[2] = '{1, 1, 1};
      tbl[3] = '{1, 2, 0};
      tbl[4] = '{7, 0, 56};
      tbl[5] = '{7, 3, 35};
      tbl[6] = '{7, 7, 7};
      tbl[7] = '{14, 7, 63};
      tbl[8] = '{14, 6, 0};
      tbl[9] = '{14, 0, 0};

      rst = 1'b1;
      tick();
      tick();
      chk("rst_busy", int'(bus_if.busy), 0);
      chk("rst_valid", int'(bus_if.a_valid), 0);
      chk("rst_done", int'(bus_if.done), 0);
      chk64("rst_aout", bus_if.a_out, '0);
      rst = 1'b0;
      tick();

      // Ramp matrix, full pass, hand-computed lane table.
      for (int r = 0; r < D; r++) write_row(r, 1'b1, 0);
      run_pass("ramp", -1, -1, 0);
      check_pass("ramp", -1, 0);
      for (int i = 0; i < 10; i++)
         chk_lane($sformatf("tbl%0d", i), tbl[i].k, tbl[i].lane, tbl[i].exp);

      // Signed extremes in rows 0 and 7.
      write_row(0, 1'b0, -128);
      write_row(7, 1'b0, 127);
      run_pass("signed", -1, -1, 0);
      check_pass("signed", -1, 0);
      chk_lane("signed_l0_k0", 0, 0, -128);
      chk_lane("signed_l0_k7", 7, 0, 127);
      chk_lane("signed_l7_k7", 7, 7, -128);
      chk_lane("signed_l7_k14", 14, 7, 127);

      // Write attempted mid-FEED must be dropped.
      run_pass("midwr", 3, -1, 0);
      check_pass("midwr", -1, 0);
      run_pass("midwr2", -1, -1, 0);
      check_pass("midwr2", -1, 0);
      chk_lane("midwr2_row3_lane0", 3, 0, 24);

      // Write in the same cycle as start is visible to the pass.
      bus_if.wr_en  = 1'b1;
      bus_if.wr_row = 3'd0;
      bus_if.a_in   = row_data(0, 1'b0, 9);
      model_row(0, 1'b0, 9);
      run_pass("samecyc", -1, -1, 0);
      check_pass("samecyc", -1, 0);
      chk_lane("samecyc_lane0", 0, 0, 9);

      // Reset at the fifth valid cycle aborts the pass and clears storage.
      begin
         int nvalid = 0;
         bus_if.start = 1'b1;
         tick();
         bus_if.start = 1'b0;
         for (int t = 0; t < 40 && nvalid < 5; t++) begin
            tick();
            if (bus_if.a_valid) nvalid++;
         end
         chk("abort_reached_5th", nvalid, 5);
         rst = 1'b1;
         tick();
         chk("abort_valid", int'(bus_if.a_valid), 0);
         chk("abort_busy", int'(bus_if.busy), 0);
         chk("abort_done", int'(bus_if.done), 0);
         rst = 1'b0;
         tick();
         chk("abort_no_done", int'(bus_if.done), 0);
         for (int r = 0; r < D; r++) model_row(r, 1'b0, 0);
      end
      run_pass("zeros", -1, -1, 0);
      check_pass("zeros", -1, 0);

`ifdef MEM_A_FEEDER_STALL_EN
      for (int r = 0; r < D; r++) write_row(r, 1'b1, 0);
      run_pass("stall", -1, 4, 3);
      check_pass("stall", 4, 3);
      chk("stall_span", cols.size(), 18);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
